// File: rtl/mbinit_pkg.sv
// Shared MBINIT definitions: sideband message codes, substep FSM states and
// clock-lane result bit positions. Used by REPAIRCLK, REPAIRVAL and the
// partner responder so that all of them agree on the encodings.
package mbinit_pkg;

  // Sideband message encodings for the REPAIRCLK exchange
  localparam logic [3:0] MSG_NONE        = 4'd0;
  localparam logic [3:0] MSG_INIT_REQ    = 4'd1;
  localparam logic [3:0] MSG_INIT_RESP   = 4'd2;
  localparam logic [3:0] MSG_RESULT_REQ  = 4'd3;
  localparam logic [3:0] MSG_RESULT_RESP = 4'd4;
  localparam logic [3:0] MSG_DONE_REQ    = 4'd5;
  localparam logic [3:0] MSG_DONE_RESP   = 4'd6;

  // Substep FSM states
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_TX_INIT = 4'd1,
    ST_WT_INIT = 4'd2,
    ST_PATTERN = 4'd3,
    ST_TX_RES  = 4'd4,
    ST_WT_RES  = 4'd5,
    ST_CHECK   = 4'd6,
    ST_TX_DONE = 4'd7,
    ST_WT_DONE = 4'd8,
    ST_DONE    = 4'd9,
    ST_ERROR   = 4'd10
  } state_e;

  // Bit positions inside the RESULT_RESP clock result {RTRK, RCKN, RCKP}
  localparam int RES_RCKP = 0;
  localparam int RES_RCKN = 1;
  localparam int RES_RTRK = 2;

  // A clock-lane result passes only if every lane reported a pass
  function automatic logic clk_result_pass(input logic [2:0] res);
    return res[RES_RCKP] & res[RES_RCKN] & res[RES_RTRK];
  endfunction

endpackage

// File: rtl/mbinit_timeout_cnt.sv
// Per-substep timeout counter shared by the MBINIT substeps. Counts while
// enabled, clears on request, and flags expiry once it holds the last count.
// The count saturates so a stalled FSM cannot wrap back below the limit.
module mbinit_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 8000,
  parameter int TO_W           = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] LAST_CNT = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] ONE_CNT  = TO_W'(1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up to the last value and hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST_CNT)) begin
      cnt_d = cnt_q + ONE_CNT;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/mbinit_repairclk_module.sv
// Initiator-side MBINIT.REPAIRCLK controller. Runs the sideband handshake
// (INIT, clock pattern, RESULT, DONE), checks the partner's clock-lane
// result and raises either the substep-end level or a train-error request.
module mbinit_repairclk_module
  import mbinit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8000,
  parameter int TO_W           = 16
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       i_enable,
  input  logic       i_CLK_Pattern_done,
  input  logic [3:0] i_Rx_SbMessage,
  input  logic       i_msg_valid,
  input  logic [2:0] i_Rx_clk_result,
  input  logic       i_Busy_SideBand,
  output logic [3:0] o_TX_SbMessage,
  output logic       o_ValidOutData,
  output logic       o_REPAIRCLK_Pattern_En,
  output logic       o_MBINIT_REPAIRCLK_end,
  output logic       o_train_error_req
);

  state_e     state_q, state_d;
  logic [2:0] res_q, res_d;
  logic       valid_q, valid_d;
  logic [3:0] tx_msg_q, tx_msg_d;
  logic       pat_en_q;
  logic       end_q;
  logic       err_q;

  logic       expired_s;
  logic       cnt_en_s;
  logic       cnt_clr_s;
  logic       init_resp_s;
  logic       result_resp_s;
  logic       done_resp_s;

  assign init_resp_s   = i_msg_valid && (i_Rx_SbMessage == MSG_INIT_RESP);
  assign result_resp_s = i_msg_valid && (i_Rx_SbMessage == MSG_RESULT_RESP);
  assign done_resp_s   = i_msg_valid && (i_Rx_SbMessage == MSG_DONE_RESP);

  // Next-state and TX request: a matching event beats the timeout, a TX
  // state only fires once the sideband is free, and dropping enable always
  // returns to IDLE.
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    valid_d  = 1'b0;
    tx_msg_d = MSG_NONE;
    if (!i_enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_TX_INIT;
        end
        ST_TX_INIT: begin
          if (expired_s) begin
            state_d = ST_ERROR;
          end else if (!i_Busy_SideBand) begin
            valid_d  = 1'b1;
            tx_msg_d = MSG_INIT_REQ;
            state_d  = ST_WT_INIT;
          end else begin
            state_d = ST_TX_INIT;
          end
        end
        ST_WT_INIT: begin
          if (init_resp_s) begin
            state_d = ST_PATTERN;
          end else if (expired_s) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_WT_INIT;
          end
        end
        ST_PATTERN: begin
          if (i_CLK_Pattern_done) begin
            state_d = ST_TX_RES;
          end else if (expired_s) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_PATTERN;
          end
        end
        ST_TX_RES: begin
          if (expired_s) begin
            state_d = ST_ERROR;
          end else if (!i_Busy_SideBand) begin
            valid_d  = 1'b1;
            tx_msg_d = MSG_RESULT_REQ;
            state_d  = ST_WT_RES;
          end else begin
            state_d = ST_TX_RES;
          end
        end
        ST_WT_RES: begin
          if (result_resp_s) begin
            res_d   = i_Rx_clk_result;
            state_d = ST_CHECK;
          end else if (expired_s) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_WT_RES;
          end
        end
        ST_CHECK: begin
          if (clk_result_pass(res_q)) begin
            state_d = ST_TX_DONE;
          end else begin
            state_d = ST_ERROR;
          end
        end
        ST_TX_DONE: begin
          if (expired_s) begin
            state_d = ST_ERROR;
          end else if (!i_Busy_SideBand) begin
            valid_d  = 1'b1;
            tx_msg_d = MSG_DONE_REQ;
            state_d  = ST_WT_DONE;
          end else begin
            state_d = ST_TX_DONE;
          end
        end
        ST_WT_DONE: begin
          if (done_resp_s) begin
            state_d = ST_DONE;
          end else if (expired_s) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_WT_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Timeout runs in every waiting/transmitting state and restarts on each
  // state change; stray messages do not touch it.
  always_comb begin
    cnt_clr_s = (state_d != state_q) || !i_enable;
    if ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR)) begin
      cnt_en_s = 1'b0;
    end else begin
      cnt_en_s = 1'b1;
    end
  end

  mbinit_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_timeout (
    .clk_i    (CLK),
    .rst_i    (rst),
    .clr_i    (cnt_clr_s),
    .en_i     (cnt_en_s),
    .expired_o(expired_s)
  );

  // State, latched result and registered outputs derived from the next state
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      res_q    <= 3'b000;
      valid_q  <= 1'b0;
      tx_msg_q <= MSG_NONE;
      pat_en_q <= 1'b0;
      end_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      valid_q  <= valid_d;
      tx_msg_q <= tx_msg_d;
      pat_en_q <= (state_d == ST_PATTERN);
      end_q    <= (state_d == ST_DONE);
      err_q    <= (state_d == ST_ERROR);
    end
  end

  assign o_TX_SbMessage         = tx_msg_q;
  assign o_ValidOutData         = valid_q;
  assign o_REPAIRCLK_Pattern_En = pat_en_q;
  assign o_MBINIT_REPAIRCLK_end = end_q;
  assign o_train_error_req      = err_q;

endmodule

// File: tb/tb_mbinit_repairclk_module.sv
// Self-checking bench for mbinit_repairclk_module. Expected timing is derived
// from the handshake rules: request pulses, response latencies, timeout
// length and the pass/fail rule on the three clock-lane results.
module tb_mbinit_repairclk_module;

  localparam int T = 160;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       pat_done;
  logic [3:0] rx_msg;
  logic       msg_valid;
  logic [2:0] rx_res;
  logic       busy;
  logic [3:0] tx_msg;
  logic       valid;
  logic       pat_en;
  logic       end_o;
  logic       err;

  int n_assert = 0;
  int n_fail   = 0;
  logic prev_v = 1'b0;

  mbinit_repairclk_module #(.TIMEOUT_CYCLES(T), .TO_W(16)) dut (
    .CLK                   (clk),
    .rst                   (rst),
    .i_enable              (enable),
    .i_CLK_Pattern_done    (pat_done),
    .i_Rx_SbMessage        (rx_msg),
    .i_msg_valid           (msg_valid),
    .i_Rx_clk_result       (rx_res),
    .i_Busy_SideBand       (busy),
    .o_TX_SbMessage        (tx_msg),
    .o_ValidOutData        (valid),
    .o_REPAIRCLK_Pattern_En(pat_en),
    .o_MBINIT_REPAIRCLK_end(end_o),
    .o_train_error_req     (err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, want);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, want);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    chk1("no_back_to_back_valid", prev_v & valid, 1'b0);
    prev_v = valid;
  endtask

  task automatic all_zero(input string tag);
    chk1(tag, valid | pat_en | end_o | err, 1'b0);
    chk4(tag, tx_msg, 4'd0);
  endtask

  task automatic send(input logic [3:0] code);
    rx_msg = code;
    msg_valid = 1'b1;
  endtask

  task automatic unsend();
    rx_msg = 4'd0;
    msg_valid = 1'b0;
  endtask

  task automatic disable_dut();
    enable = 1'b0;
    tick();
    all_zero("disable_clears");
    tick();
  endtask

  // One REPAIRCLK attempt.
  // b: busy cycles at start; d_init/d_res/d_done: response delays (cycles
  // after the request pulse); p: pattern length; res: partner result.
  // mode 0 normal, 1 abort in WT_RES, 2 async reset in PATTERN,
  // 3 no INIT_RESP (timeout).
  task automatic session(input int b, input int d_init, input int p, input int d_res,
                         input logic [2:0] res, input int d_done, input int mode);
    int exp_t;
    enable = 1'b1;
    busy = (b > 0);
    exp_t = (b > 0) ? b + 1 : 2;
    for (int k = 1; k <= exp_t; k++) begin
      tick();
      if (k < exp_t) begin
        chk1("init_req_held", valid, 1'b0);
      end else begin
        chk1("init_req_valid", valid, 1'b1);
        chk4("init_req_code", tx_msg, 4'd1);
      end
      if (k == b) busy = 1'b0;
    end

    if (mode == 3) begin
      for (int k = 1; k <= T; k++) begin
        tick();
        chk1("timeout_err", err, (k == T));
        chk1("timeout_no_valid", valid, 1'b0);
      end
      tick();
      chk1("timeout_err_hold", err, 1'b1);
      chk1("timeout_no_end", end_o, 1'b0);
      disable_dut();
      return;
    end

    for (int k = 1; k <= d_init; k++) begin
      if (k == 2) pat_done = 1'b1;
      tick();
      pat_done = 1'b0;
      chk1("wt_init_quiet", valid | pat_en | err, 1'b0);
    end
    send(4'd2);
    tick();
    unsend();
    chk1("pattern_en_on", pat_en, 1'b1);
    chk1("pattern_no_err", err, 1'b0);

    for (int k = 1; k <= p; k++) begin
      if (k == 1) send(4'd6);
      else if (k == 3) send(4'd2);
      else unsend();
      tick();
      unsend();
      chk1("pattern_en_hold", pat_en, 1'b1);
      chk1("pattern_no_valid", valid, 1'b0);
    end

    if (mode == 2) begin
      #2;
      rst = 1'b1;
      #1;
      all_zero("async_rst_clears");
      enable = 1'b0;
      #2;
      rst = 1'b0;
      prev_v = 1'b0;
      tick();
      all_zero("after_rst_idle");
      return;
    end

    pat_done = 1'b1;
    tick();
    pat_done = 1'b0;
    chk1("pattern_en_off", pat_en, 1'b0);
    chk1("tx_res_wait", valid, 1'b0);
    tick();
    chk1("result_req_valid", valid, 1'b1);
    chk4("result_req_code", tx_msg, 4'd3);

    for (int k = 1; k <= d_res; k++) begin
      if (mode == 1 && k == 2) begin
        enable = 1'b0;
        tick();
        all_zero("abort_clears");
        tick();
        all_zero("abort_stays_idle");
        return;
      end
      if (k == 1) send(4'd6);
      else if (k == 3) send(4'd2);
      else unsend();
      if (k == 2) pat_done = 1'b1;
      tick();
      unsend();
      pat_done = 1'b0;
      chk1("wt_res_quiet", valid | pat_en | err, 1'b0);
    end

    rx_res = res;
    send(4'd4);
    tick();
    unsend();
    rx_res = $urandom_range(0, 7);
    chk1("check_no_err", err, 1'b0);
    chk1("check_no_valid", valid, 1'b0);
    tick();
    if (&res) begin
      chk1("pass_no_err", err, 1'b0);
      chk1("pass_tx_done_wait", valid, 1'b0);
      tick();
      chk1("done_req_valid", valid, 1'b1);
      chk4("done_req_code", tx_msg, 4'd5);
      for (int k = 1; k <= d_done; k++) begin
        tick();
        chk1("wt_done_quiet", valid | end_o | err, 1'b0);
      end
      send(4'd6);
      tick();
      unsend();
      chk1("end_rises", end_o, 1'b1);
      chk1("end_no_err", err, 1'b0);
      for (int k = 0; k < 3; k++) begin
        tick();
        chk1("end_hold", end_o, 1'b1);
        chk1("end_no_valid", valid, 1'b0);
      end
    end else begin
      chk1("fail_err", err, 1'b1);
      chk1("fail_no_end", end_o, 1'b0);
      for (int k = 0; k < 3; k++) begin
        tick();
        chk1("fail_err_hold", err, 1'b1);
        chk1("fail_no_done_req", valid, 1'b0);
      end
    end
    disable_dut();
  endtask

  initial begin
    int b, di, p, dr, dd;
    logic [2:0] r;
    rst = 1'b1;
    enable = 1'b0;
    pat_done = 1'b0;
    rx_msg = 4'd0;
    msg_valid = 1'b0;
    rx_res = 3'b000;
    busy = 1'b0;
    @(posedge clk);
    #1;
    all_zero("reset_outputs");
    #2;
    rst = 1'b0;
    tick();
    all_zero("idle_quiet");

    session(0, 5, 140, 3, 3'b111, 4, 0);      // nominal pass
    session(0, 2, 8, 3, 3'b101, 0, 0);        // lane fail
    session(10, 4, 6, 2, 3'b111, 1, 0);       // busy back-pressure
    session(0, 0, 0, 0, 3'b000, 0, 3);        // timeout without INIT_RESP
    session(0, 3, 10, T - 1, 3'b111, 2, 0);   // RESULT_RESP on expiry cycle
    session(0, T - 1, 5, 1, 3'b110, 0, 0);    // INIT_RESP on expiry cycle, lane fail
    session(0, 3, 6, 5, 3'b111, 0, 1);        // abort in WT_RES
    session(2, 3, 6, 5, 3'b111, 0, 2);        // async reset in PATTERN
    session(0, 1, 4, 0, 3'b011, 0, 0);        // immediate responses, lane fail

    for (int s = 0; s < 12; s++) begin
      b  = $urandom_range(0, 6);
      di = $urandom_range(0, T - 1);
      p  = $urandom_range(4, 40);
      dr = $urandom_range(0, T - 1);
      dd = $urandom_range(0, 12);
      if ($urandom_range(0, 1) == 1) r = 3'b111;
      else r = 3'($urandom_range(0, 6));
      session(b, di, p, dr, r, dd, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
